// File: rtl/wan_pkt_assembler_if.sv
// Beat-stream ingress and router-facing packet bus of the WAN packet assembler.
// master = beat source / router side, slave = assembler.
interface wan_pkt_assembler_if #(
  parameter int WORD_W  = 8,
  parameter int PKT_LEN = 97
);
  logic              in_vld;
  logic [WORD_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              in_rdy;
  logic              congestion;
  logic [PKT_LEN-1:0] port_wan;
  logic              port_wan_vld;
  logic              frame_err;
  logic [15:0]       pkt_cnt;

  modport master (
    output in_vld, in_data, in_sop, in_eop, congestion,
    input  in_rdy, port_wan, port_wan_vld, frame_err, pkt_cnt
  );

  modport slave (
    input  in_vld, in_data, in_sop, in_eop, congestion,
    output in_rdy, port_wan, port_wan_vld, frame_err, pkt_cnt
  );
endinterface

// File: rtl/wan_pkt_assembler.sv
// Collects {dest_ip, payload} beats into one packet, appends the additive CRC the
// router checks, and strobes it into the router's WAN FIFO unless it is congested.
module wan_pkt_assembler #(
  parameter int DEST_IP_LEN = 32,
  parameter int PAYLOAD_LEN = 32,
  parameter int WORD_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  wan_pkt_assembler_if.slave bus
);
  localparam int CRC_LEN  = (DEST_IP_LEN > PAYLOAD_LEN) ? DEST_IP_LEN :
                            (PAYLOAD_LEN > DEST_IP_LEN) ? PAYLOAD_LEN : DEST_IP_LEN + 1;
  localparam int DATA_LEN = DEST_IP_LEN + PAYLOAD_LEN;
  localparam int N_BEATS  = DATA_LEN / WORD_W;
  localparam int CNT_W    = $clog2(N_BEATS + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DISCARD, CALC, SEND} state_t;

  state_t              state;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    next_cnt;
  logic [DATA_LEN-1:0] shreg;
  logic [DATA_LEN-1:0] beat_ext;
  logic [CRC_LEN-1:0]  ip_ext;
  logic [CRC_LEN-1:0]  pl_ext;
  logic [CRC_LEN-1:0]  crc;
  logic                accept;

  assign bus.in_rdy = (state == IDLE) || (state == COLLECT) || (state == DISCARD);
  assign accept     = bus.in_vld && bus.in_rdy;
  assign beat_ext   = DATA_LEN'(bus.in_data);
  assign next_cnt   = bus.in_sop ? CNT_W'(1) : beat_cnt + CNT_W'(1);

  // CRC_LEN is wide enough for either field, so the sum is formed at CRC_LEN and
  // naturally keeps the carry only when the field widths are equal.
  always_comb begin
    ip_ext = '0;
    pl_ext = '0;
    ip_ext[DEST_IP_LEN-1:0] = shreg[DATA_LEN-1 -: DEST_IP_LEN];
    pl_ext[PAYLOAD_LEN-1:0] = shreg[PAYLOAD_LEN-1:0];
    crc = ip_ext + pl_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      shreg            <= '0;
      bus.port_wan     <= '0;
      bus.port_wan_vld <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.pkt_cnt      <= '0;
    end else begin
      bus.frame_err    <= 1'b0;
      bus.port_wan_vld <= 1'b0;
      unique case (state)
        IDLE, COLLECT, DISCARD: begin
          if (accept) begin
            // A sop beat always (re)starts a packet; otherwise only COLLECT extends one.
            if (bus.in_sop || state == COLLECT) begin
              shreg    <= bus.in_sop ? beat_ext : ((shreg << WORD_W) | beat_ext);
              beat_cnt <= next_cnt;
              if (state == COLLECT && bus.in_sop) bus.frame_err <= 1'b1;
              if (bus.in_eop) begin
                if (next_cnt == CNT_W'(N_BEATS)) begin
                  state <= CALC;
                end else begin
                  bus.frame_err <= 1'b1;
                  state         <= IDLE;
                end
              end else if (next_cnt == CNT_W'(N_BEATS)) begin
                bus.frame_err <= 1'b1;
                state         <= DISCARD;
              end else begin
                state <= COLLECT;
              end
            end else if (state == IDLE) begin
              bus.frame_err <= 1'b1;
            end else if (bus.in_eop) begin
              state <= IDLE;
            end
          end
        end
        CALC: begin
          bus.port_wan <= {shreg, crc};
          if (!bus.congestion) begin
            bus.port_wan_vld <= 1'b1;
            bus.pkt_cnt      <= bus.pkt_cnt + 16'd1;
          end
          state <= SEND;
        end
        SEND: begin
          // The strobe is registered, so SEND ends in the cycle the strobe is visible.
          if (bus.port_wan_vld) begin
            state <= IDLE;
          end else if (!bus.congestion) begin
            bus.port_wan_vld <= 1'b1;
            bus.pkt_cnt      <= bus.pkt_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wan_pkt_assembler.sv
// Directed self-checking bench for wan_pkt_assembler; a scoreboard queue holds the
// packets expected on port_wan and a monitor pops them on every port_wan_vld strobe.
module tb_wan_pkt_assembler;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   vld_seen;
  int   err_seen;
  int   exp_vld;
  int   exp_err;
  logic [96:0] sb[$];
  logic [96:0] exp_pkt;

  wan_pkt_assembler_if #(.WORD_W(8), .PKT_LEN(97)) bus ();

  wan_pkt_assembler #(.DEST_IP_LEN(32), .PAYLOAD_LEN(32), .WORD_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [96:0] model(input logic [31:0] ip, input logic [31:0] pl);
    logic [32:0] c;
    c = {1'b0, ip} + {1'b0, pl};
    return {ip, pl, c};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic sop, input logic eop);
    bus.in_vld  = 1'b1;
    bus.in_data = data;
    bus.in_sop  = sop;
    bus.in_eop  = eop;
    tick();
    bus.in_vld  = 1'b0;
    bus.in_sop  = 1'b0;
    bus.in_eop  = 1'b0;
  endtask

  // Eight beats MSB-first; the expected packet is queued as the eop beat is driven.
  task automatic send_packet(input logic [31:0] ip, input logic [31:0] pl);
    logic [63:0] d;
    d = {ip, pl};
    for (int i = 0; i < 8; i++) begin
      if (i == 7) sb.push_back(model(ip, pl));
      apply_stimulus(d[63-8*i -: 8], i == 0, i == 7);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.port_wan_vld === 1'b1) begin
      vld_seen++;
      if (sb.size() == 0) check_output("vld_with_empty_sb", bus.port_wan_vld, 1'b0);
      else check_output("sb_port_wan", bus.port_wan, sb.pop_front());
    end
    if (bus.frame_err === 1'b1) err_seen++;
  end

  initial begin
    total = 0; bad = 0; vld_seen = 0; err_seen = 0; exp_vld = 0; exp_err = 0;
    rst = 1'b1;
    bus.in_vld = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.congestion = 1'b0;
    tick();
    tick();
    check_output("reset_port_wan", bus.port_wan, 97'd0);
    check_output("reset_vld", bus.port_wan_vld, 1'b0);
    check_output("reset_err", bus.frame_err, 1'b0);
    check_output("reset_pkt_cnt", bus.pkt_cnt, 16'd0);
    check_output("reset_in_rdy", bus.in_rdy, 1'b1);
    rst = 1'b0;
    tick();

    // Basic packet with exact latency: CALC at T+1, strobe at T+2, ready again at T+3.
    send_packet(32'hC0A80001, 32'h12345678);
    exp_vld++;
    check_output("t1_calc_rdy", bus.in_rdy, 1'b0);
    check_output("t1_calc_vld", bus.port_wan_vld, 1'b0);
    tick();
    check_output("t1_vld", bus.port_wan_vld, 1'b1);
    check_output("t1_port_wan", bus.port_wan, {32'hC0A80001, 32'h12345678, 33'h0D2DC5679});
    check_output("t1_pkt_cnt", bus.pkt_cnt, 16'd1);
    check_output("t1_send_rdy", bus.in_rdy, 1'b0);
    tick();
    check_output("t1_vld_drop", bus.port_wan_vld, 1'b0);
    check_output("t1_rdy_back", bus.in_rdy, 1'b1);
    check_output("t1_hold", bus.port_wan, {32'hC0A80001, 32'h12345678, 33'h0D2DC5679});

    // Back-to-back packet exercising the CRC carry bit.
    send_packet(32'hFFFFFFFF, 32'h00000002);
    exp_vld++;
    tick();
    check_output("t2_vld", bus.port_wan_vld, 1'b1);
    check_output("t2_crc", bus.port_wan[32:0], 33'h100000001);
    check_output("t2_pkt_cnt", bus.pkt_cnt, 16'd2);
    tick();

    // Congestion holds the packet; strobe appears one cycle after congestion falls.
    bus.congestion = 1'b1;
    exp_pkt = model(32'h0A0B0C0D, 32'hF0E0D0C0);
    send_packet(32'h0A0B0C0D, 32'hF0E0D0C0);
    exp_vld++;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("t3_cong_vld", bus.port_wan_vld, 1'b0);
      check_output("t3_cong_rdy", bus.in_rdy, 1'b0);
      check_output("t3_cong_hold", bus.port_wan, exp_pkt);
    end
    bus.congestion = 1'b0;
    tick();
    check_output("t3_vld", bus.port_wan_vld, 1'b1);
    check_output("t3_pkt_cnt", bus.pkt_cnt, 16'd3);
    tick();
    check_output("t3_vld_drop", bus.port_wan_vld, 1'b0);
    check_output("t3_rdy_back", bus.in_rdy, 1'b1);

    // Early eop on beat 5, then a stray beat without sop while idle.
    apply_stimulus(8'h01, 1'b1, 1'b0);
    apply_stimulus(8'h02, 1'b0, 1'b0);
    apply_stimulus(8'h03, 1'b0, 1'b0);
    apply_stimulus(8'h04, 1'b0, 1'b0);
    apply_stimulus(8'h05, 1'b0, 1'b1);
    exp_err++;
    check_output("t4_early_eop_err", bus.frame_err, 1'b1);
    check_output("t4_early_eop_rdy", bus.in_rdy, 1'b1);
    tick();
    check_output("t4_err_drop", bus.frame_err, 1'b0);
    apply_stimulus(8'h77, 1'b0, 1'b0);
    exp_err++;
    check_output("t4_no_sop_err", bus.frame_err, 1'b1);
    tick();

    // sop re-asserted on beat 4 restarts the packet from that beat.
    apply_stimulus(8'h11, 1'b1, 1'b0);
    apply_stimulus(8'h22, 1'b0, 1'b0);
    apply_stimulus(8'h33, 1'b0, 1'b0);
    apply_stimulus(8'hA0, 1'b1, 1'b0);
    exp_err++;
    check_output("t5_resop_err", bus.frame_err, 1'b1);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) sb.push_back(model(32'hA0A1A2A3, 32'hA4A5A6A7));
      apply_stimulus(8'hA0 + 8'(i), 1'b0, i == 7);
    end
    exp_vld++;
    tick();
    check_output("t5_restart_vld", bus.port_wan_vld, 1'b1);
    check_output("t5_restart_pkt", bus.port_wan, model(32'hA0A1A2A3, 32'hA4A5A6A7));
    check_output("t5_pkt_cnt", bus.pkt_cnt, 16'd4);
    tick();

    // Eight beats without eop: one error, then everything up to eop is swallowed.
    for (int i = 0; i < 8; i++) apply_stimulus(8'hB0 + 8'(i), i == 0, 1'b0);
    exp_err++;
    check_output("t5_no_eop_err", bus.frame_err, 1'b1);
    check_output("t5_discard_rdy", bus.in_rdy, 1'b1);
    apply_stimulus(8'hC0, 1'b0, 1'b0);
    check_output("t5_swallow_err", bus.frame_err, 1'b0);
    apply_stimulus(8'hC1, 1'b0, 1'b1);
    check_output("t5_swallow_eop_err", bus.frame_err, 1'b0);
    tick();
    tick();
    check_output("t5_discard_no_vld", bus.port_wan_vld, 1'b0);
    check_output("t5_discard_pkt_cnt", bus.pkt_cnt, 16'd4);

    // Reset in the middle of COLLECT.
    apply_stimulus(8'h55, 1'b1, 1'b0);
    apply_stimulus(8'h66, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_output("t6_collect_rst_cnt", bus.pkt_cnt, 16'd0);
    check_output("t6_collect_rst_wan", bus.port_wan, 97'd0);
    check_output("t6_collect_rst_rdy", bus.in_rdy, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // Reset while a congested packet waits in SEND.
    bus.congestion = 1'b1;
    send_packet(32'hDEADBEEF, 32'h01020304);
    tick();
    check_output("t6_send_rdy", bus.in_rdy, 1'b0);
    rst = 1'b1;
    #1;
    sb.delete();
    check_output("t6_send_rst_wan", bus.port_wan, 97'd0);
    check_output("t6_send_rst_vld", bus.port_wan_vld, 1'b0);
    check_output("t6_send_rst_err", bus.frame_err, 1'b0);
    bus.congestion = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_output("t6_post_rst_vld", bus.port_wan_vld, 1'b0);
    check_output("t6_post_rst_rdy", bus.in_rdy, 1'b1);

    // Counter wrap from 0xFFFF.
    force bus.pkt_cnt = 16'hFFFF;
    #1;
    release bus.pkt_cnt;
    #1;
    check_output("t6_preset_cnt", bus.pkt_cnt, 16'hFFFF);
    send_packet(32'h01010101, 32'h02020202);
    exp_vld++;
    tick();
    check_output("t6_wrap_vld", bus.port_wan_vld, 1'b1);
    check_output("t6_wrap_cnt", bus.pkt_cnt, 16'h0000);
    tick();
    tick();

    check_output("sb_drained", 128'(sb.size()), 128'd0);
    check_output("vld_count", 128'(vld_seen), 128'(exp_vld));
    check_output("err_count", 128'(err_seen), 128'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
